// File: rtl/regfile_port_arbiter.sv
// Shares the register file ports between the pipeline and a debug port.
// Debug writes use the write port when the pipeline leaves it idle; debug reads freeze the pipeline for one cycle.
module regfile_port_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] pl_ra1,
    input  logic                     pl_we,
    input  logic [ADDRESS_WIDTH-1:0] pl_waddr,
    input  logic [DATA_WIDTH-1:0]    pl_wdata,
    input  logic                     dbg_req,
    input  logic                     dbg_wr,
    input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]    dbg_wdata,
    output logic                     dbg_ack,
    output logic [DATA_WIDTH-1:0]    dbg_rdata,
    output logic                     stall_req,
    output logic [ADDRESS_WIDTH-1:0] rf_a1,
    input  logic [DATA_WIDTH-1:0]    rf_rd1,
    output logic [ADDRESS_WIDTH-1:0] rf_a3,
    output logic [DATA_WIDTH-1:0]    rf_wd3,
    output logic                     rf_we3
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, PEND, STALL, ACK} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     hold_wr_q, hold_wr_d;
    logic [ADDRESS_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_wr_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_wr_q   <= hold_wr_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_wr_d   = hold_wr_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        rdata_d     = rdata_q;
        rf_a1       = pl_ra1;
        rf_a3       = pl_waddr;
        rf_wd3      = pl_wdata;
        rf_we3      = pl_we;
        stall_req   = 1'b0;
        dbg_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    hold_wr_d   = dbg_wr;
                    hold_addr_d = dbg_addr;
                    hold_data_d = dbg_wdata;
                    cnt_d       = '0;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (!hold_wr_q) begin
                    // Read port 1 is only ours while the pipeline is frozen.
                    state_d = STALL;
                end else if (!pl_we) begin
                    rf_a3   = hold_addr_q;
                    rf_wd3  = hold_data_q;
                    rf_we3  = (hold_addr_q != '0);
                    state_d = ACK;
                end else begin
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = STALL;
                end
            end
            STALL: begin
                stall_req = 1'b1;
                rf_a1     = hold_addr_q;
                if (!pl_we) begin
                    if (hold_wr_q) begin
                        rf_a3  = hold_addr_q;
                        rf_wd3 = hold_data_q;
                        rf_we3 = (hold_addr_q != '0);
                    end else begin
                        rdata_d = (hold_addr_q == '0) ? '0 : rf_rd1;
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                dbg_ack = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter: expected read data queued at request, checked at ack.
module tb_regfile_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pl_ra1 = '0;
    logic          pl_we = 1'b1;
    logic [AW-1:0] pl_waddr = '0;
    logic [DW-1:0] pl_wdata = '0;
    logic          dbg_req = 1'b0;
    logic          dbg_wr = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          stall_req;
    logic [AW-1:0] rf_a1;
    logic [DW-1:0] rf_rd1;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd3;
    logic          rf_we3;

    logic [DW-1:0] rf_model [32];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd = '0;
    int            n_err = 0;
    int            n_chk = 0;

    always #5 clk = ~clk;
    always_comb rf_rd1 = rf_model[rf_a1];

    regfile_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .pl_ra1(pl_ra1), .pl_we(pl_we), .pl_waddr(pl_waddr),
        .pl_wdata(pl_wdata), .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .stall_req(stall_req),
        .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_wr = wr; dbg_addr = addr; dbg_wdata = data;
        if (!wr) last_rd = (addr == '0) ? '0 : rf_model[addr];
        exp_q.push_back(last_rd);
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    task automatic wait_ack(input int max, output int cyc, output int stalls, output int dbgw,
                            output logic [AW-1:0] a1_st, output logic [AW-1:0] a3_w,
                            output logic [DW-1:0] wd_w);
        logic          got;
        logic [DW-1:0] e;
        got = 1'b0; cyc = 0; stalls = 0; dbgw = 0; a1_st = '0; a3_w = '0; wd_w = '0;
        for (int i = 1; i <= max && !got; i++) begin
            @(negedge clk);
            if (stall_req) begin stalls++; a1_st = rf_a1; end
            if (rf_we3 && !pl_we) begin dbgw++; a3_w = rf_a3; wd_w = rf_wd3; end
            if (dbg_ack) begin
                got = 1'b1; cyc = i;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk("ack_rdata", dbg_rdata, e);
            end
        end
        if (!got) begin
            chk("ack_timeout", 32'(got), 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            @(negedge clk);
            chk("ack_one_cycle", 32'(dbg_ack), 32'd0);
            chk("stall_after_ack", 32'(stall_req), 32'd0);
        end
    endtask

    task automatic wait_stall(input int max, output int blocked);
        logic seen;
        seen = 1'b0; blocked = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (stall_req) seen = 1'b1;
            else blocked++;
        end
        chk("stall_reached", 32'(seen), 32'd1);
    endtask

    initial begin
        int            cyc, stalls, dbgw, blocked, acks;
        logic [AW-1:0] a1_st, a3_w;
        logic [DW-1:0] wd_w;

        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0101_0101 * 32'(i) ^ 32'h5A5A_0000;
        rf_model[0]  = 32'hFFFF_FFFF;
        rf_model[10] = 32'h0000_0042;

        // Reset state; write port follows the pipeline while in reset
        #2;
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_we_follow", 32'(rf_we3), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; pl_we = 1'b0; pl_ra1 = 5'd2; pl_waddr = 5'd3; pl_wdata = 32'hCAFE_F00D;

        // Write x5 with idle pipeline write port
        issue(1'b1, 5'd5, 32'hDEAD_BEEF);
        wait_ack(6, cyc, stalls, dbgw, a1_st, a3_w, wd_w);
        chk("w5_latency", 32'(cyc), 32'd2);
        chk("w5_stalls", 32'(stalls), 32'd0);
        chk("w5_dbgw", 32'(dbgw), 32'd1);
        chk("w5_a3", 32'(a3_w), 32'd5);
        chk("w5_wd3", wd_w, 32'hDEAD_BEEF);

        // Read x10 freezes the pipeline for one cycle
        issue(1'b0, 5'd10, '0);
        wait_ack(6, cyc, stalls, dbgw, a1_st, a3_w, wd_w);
        chk("r10_latency", 32'(cyc), 32'd3);
        chk("r10_stalls", 32'(stalls), 32'd1);
        chk("r10_a1", 32'(a1_st), 32'd10);
        chk("r10_dbgw", 32'(dbgw), 32'd0);
        chk("r10_a1_pipe", 32'(rf_a1), 32'd2);

        // Write x7 starved by pipeline writes, then forced stall
        pl_we = 1'b1;
        issue(1'b1, 5'd7, 32'h1234_5678);
        chk("starve_pass_a3", 32'(rf_a3), 32'd3);
        wait_stall(20, blocked);
        chk("starve_blocked", 32'(blocked), 32'd8);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_hold", 32'(stall_req), 32'd1);
        chk("stall_pipe_we", 32'(rf_we3), 32'd1);
        chk("stall_pipe_wd", rf_wd3, 32'hCAFE_F00D);
        @(posedge clk); #1;
        pl_we = 1'b0;
        wait_ack(6, cyc, stalls, dbgw, a1_st, a3_w, wd_w);
        chk("w7_latency", 32'(cyc), 32'd2);
        chk("w7_dbgw", 32'(dbgw), 32'd1);
        chk("w7_a3", 32'(a3_w), 32'd7);
        chk("w7_wd3", wd_w, 32'h1234_5678);

        // Read x0 returns zero regardless of rf_rd1
        issue(1'b0, 5'd0, '0);
        wait_ack(6, cyc, stalls, dbgw, a1_st, a3_w, wd_w);
        chk("r0_latency", 32'(cyc), 32'd3);

        // Write x0 completes without touching the register file
        issue(1'b1, 5'd0, 32'h1);
        wait_ack(6, cyc, stalls, dbgw, a1_st, a3_w, wd_w);
        chk("w0_latency", 32'(cyc), 32'd2);
        chk("w0_dbgw", 32'(dbgw), 32'd0);

        // Second request while pending is ignored
        pl_we = 1'b1;
        issue(1'b1, 5'd9, 32'h99);
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd10;
        repeat (2) begin @(posedge clk); #1; end
        dbg_req = 1'b0; pl_we = 1'b0;
        wait_ack(6, cyc, stalls, dbgw, a1_st, a3_w, wd_w);
        chk("dup_a3", 32'(a3_w), 32'd9);
        acks = 0;
        repeat (6) begin @(negedge clk); if (dbg_ack || stall_req) acks++; end
        chk("dup_no_second", 32'(acks), 32'd0);

        // Reset asserted during STALL drops the request
        pl_we = 1'b1;
        issue(1'b1, 5'd12, 32'hABCD_0123);
        wait_stall(20, blocked);
        @(posedge clk); #3;
        rst_n = 1'b0; pl_we = 1'b0;
        #1;
        chk("rst_stall_drop", 32'(stall_req), 32'd0);
        chk("rst_no_ack", 32'(dbg_ack), 32'd0);
        chk("rst_no_we", 32'(rf_we3), 32'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0; dbgw = 0;
        repeat (4) begin
            @(negedge clk);
            if (dbg_ack) acks++;
            if (rf_we3) dbgw++;
        end
        chk("post_rst_no_ack", 32'(acks), 32'd0);
        chk("post_rst_no_write", 32'(dbgw), 32'd0);
        issue(1'b0, 5'd10, '0);
        wait_ack(6, cyc, stalls, dbgw, a1_st, a3_w, wd_w);
        chk("post_rst_latency", 32'(cyc), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH, default 5, register address width; DATA_WIDTH, default 32, register data width; STARVE_LIMIT, default 8, blocked pipeline-write cycles before a forced stall.
REQ-002 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- pl_ra1  in  ADDRESS_WIDTH  pipeline read address, port 1
- pl_we  in  1  pipeline writeback enable
- pl_waddr  in  ADDRESS_WIDTH  pipeline writeback address
- pl_wdata  in  DATA_WIDTH  pipeline writeback data
- dbg_req  in  1  debug request strobe
- dbg_wr  in  1  1 = write, 0 = read
- dbg_addr  in  ADDRESS_WIDTH  debug register address
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_WIDTH  debug read result, valid with dbg_ack
- stall_req  out  1  pipeline freeze request to hazard unit
- rf_a1  out  ADDRESS_WIDTH  register file read address 1
- rf_rd1  in  DATA_WIDTH  register file read data 1
- rf_a3  out  ADDRESS_WIDTH  register file write address
- rf_wd3  out  DATA_WIDTH  register file write data
- rf_we3  out  1  register file write enable

Function
REQ-004 The FSM SHALL have four states: IDLE, PEND, STALL, ACK.
REQ-005 In IDLE, dbg_req=1 SHALL latch dbg_wr, dbg_addr and dbg_wdata into hold registers, clear the wait counter, and move to PEND; in any other state dbg_req SHALL be ignored.
REQ-006 Default muxing (IDLE, ACK, and PEND when not serving): rf_a1=pl_ra1, rf_a3=pl_waddr, rf_wd3=pl_wdata, rf_we3=pl_we.
REQ-007 PEND, held write, pl_we=0: the same cycle SHALL drive rf_a3=held addr, rf_wd3=held data, rf_we3=(held addr!=0), then move to ACK.
REQ-008 PEND, held write, pl_we=1: the pipeline write SHALL pass through and the wait counter SHALL increment; when the counter equals STARVE_LIMIT-1 at that edge, the next state SHALL be STALL.
REQ-009 PEND, held read: the next state SHALL be STALL unconditionally, because read port 1 belongs to the pipeline outside STALL.
REQ-010 In STALL, stall_req SHALL be 1 and rf_a1 SHALL equal the held addr.
REQ-011 STALL, pl_we=1: the pipeline write SHALL pass through, and the state SHALL remain STALL.
REQ-012 STALL, pl_we=0: the held write SHALL be performed as in REQ-007, or for a read, rf_rd1 SHALL be captured into dbg_rdata; the next state SHALL be ACK.
REQ-013 A debug read of address 0 SHALL return 0 regardless of rf_rd1.
REQ-014 A debug write to address 0 SHALL complete and acknowledge with rf_we3=0.
REQ-015 ACK SHALL assert dbg_ack=1 for exactly one cycle with dbg_rdata stable, deassert stall_req, and return to IDLE.
REQ-016 dbg_rdata SHALL hold its value until the next completed read.
REQ-017 After a write, dbg_rdata SHALL be unchanged.
REQ-018 The wait counter SHALL saturate and never wrap.
REQ-019 stall_req SHALL be 0 in every state except STALL.
REQ-020 Minimum latency from dbg_req to dbg_ack SHALL be 2 cycles for a write and 3 cycles for a read.

Reset
REQ-021 rst_n=0 SHALL immediately force: state IDLE; counter, hold registers and dbg_rdata to 0; dbg_ack=0; stall_req=0. In this condition rf_we3 follows pl_we.
REQ-022 Reset during PEND, STALL or ACK SHALL drop the request with no ack and no debug write.
REQ-023 After rst_n rises, the first dbg_req SHALL be accepted on the next rising clk edge.

Verification
REQ-024 Scenario: write x5=0xDEADBEEF with pl_we=0 -> rf_we3=1, rf_a3=5, rf_wd3=0xDEADBEEF in the PEND cycle; dbg_ack one cycle later; stall_req never 1.
REQ-025 Scenario: write x7=0x12345678 with pl_we held at 1 -> 8 blocked cycles, then STALL; the write lands on the first pl_we=0 cycle; dbg_ack follows.
REQ-026 Scenario: rf_rd1 returns 0x00000042 for address 10, then read x10 -> stall_req=1 for one cycle, rf_a1=10, dbg_rdata=0x00000042 with dbg_ack.
REQ-027 Scenario: read x0 while rf_rd1=0xFFFFFFFF -> dbg_rdata=0. Then write x0=0x1 -> dbg_ack with rf_we3 never driven by the debug write.
REQ-028 Scenario: second dbg_req issued while in PEND -> ignored; exactly one dbg_ack results.
REQ-029 Scenario: rst_n pulled low during STALL -> stall_req=0 immediately, no dbg_ack, no debug write; the next request completes normally.
